// File: rtl/opti_result_capture.sv
// rtl/opti_result_capture.sv - captures stable filter samples into a buffer and replays them over a valid/ready port
// Optional peak-magnitude tracking is enabled by defining OPTI_CAPTURE_PEAK_EN.
module opti_result_capture #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_stable,
    input  logic              in_done,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [ADDR_W:0]   cap_count,
    output logic              busy,
    output logic              overflow,
    output logic              cap_done,
    output logic [DATA_W-1:0] peak_abs
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   cnt_nx;
    logic              start, wr_en, wr_ok;
    logic              rd_en, pop, fpop, push;
    logic [DATA_W-1:0] ram_q;
    logic              q_pend, q_last;
    logic [DATA_W-1:0] f_data0, f_data1;
    logic              f_last0, f_last1;
    logic [1:0]        f_cnt;
    logic [1:0]        f_base;
    logic [2:0]        occ_after;

    always_comb begin
        start    = ((state == S_IDLE) || (state == S_DONE)) && arm;
        wr_en    = (state == S_CAPTURE) && in_valid && in_stable;
        wr_ok    = wr_en && (cap_count < DEPTH_C);
        cnt_nx   = wr_ok ? cap_count + ONE_C : cap_count;

        // Output stage: a 2-entry skid FIFO, bypassed by the RAM output when empty
        rd_valid = (f_cnt != 2'd0) || q_pend;
        rd_data  = (f_cnt != 2'd0) ? f_data0 : (q_pend ? ram_q : '0);
        rd_last  = (f_cnt != 2'd0) ? f_last0 : (q_pend && q_last);
        pop      = rd_valid && rd_ready;
        fpop     = pop && (f_cnt != 2'd0);
        push     = q_pend && !(pop && (f_cnt == 2'd0));
        f_base   = f_cnt - {1'b0, fpop};
        occ_after = {1'b0, f_cnt} + {2'b0, q_pend} - {2'b0, pop};
        rd_en    = (state == S_DRAIN) && (rd_ptr < cap_count) && (occ_after < 3'd2);

        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (arm) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                if (in_done) state_nx = (cnt_nx != '0) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: if (pop && rd_last) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cap_count <= '0;
            overflow  <= 1'b0;
            cap_done  <= 1'b0;
            rd_ptr    <= '0;
            q_pend    <= 1'b0;
            q_last    <= 1'b0;
            f_cnt     <= 2'd0;
            f_data0   <= '0;
            f_data1   <= '0;
            f_last0   <= 1'b0;
            f_last1   <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == S_CAPTURE) || (state_nx == S_DRAIN);
            if (start) begin
                cap_count <= '0;
                overflow  <= 1'b0;
                cap_done  <= 1'b0;
                rd_ptr    <= '0;
            end else begin
                if (wr_ok) cap_count <= cnt_nx;
                if (wr_en && !wr_ok) overflow <= 1'b1;
                if ((state_nx == S_DONE) && (state != S_DONE)) cap_done <= 1'b1;
                if (rd_en) begin
                    rd_ptr <= rd_ptr + ONE_C;
                    q_last <= (rd_ptr == cap_count - ONE_C);
                end
            end
            q_pend <= rd_en;
            f_cnt  <= f_base + {1'b0, push};
            if (fpop) begin
                f_data0 <= f_data1;
                f_last0 <= f_last1;
            end
            if (push) begin
                if (f_base == 2'd0) begin
                    f_data0 <= ram_q;
                    f_last0 <= q_last;
                end else begin
                    f_data1 <= ram_q;
                    f_last1 <= q_last;
                end
            end
        end
    end

    // Plain synchronous RAM, no reset, so it maps onto block memory
    always_ff @(posedge clk) begin
        if (wr_ok) mem[cap_count[ADDR_W-1:0]] <= in_data;
        if (rd_en) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
    end

`ifdef OPTI_CAPTURE_PEAK_EN
    logic [DATA_W-1:0] in_abs;

    always_comb begin
        in_abs = in_data;
        if (in_data[DATA_W-1]) begin
            // Most negative value has no positive counterpart; clamp to max positive
            if (in_data == {1'b1, {(DATA_W-1){1'b0}}}) in_abs = {1'b0, {(DATA_W-1){1'b1}}};
            else                                       in_abs = -in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         peak_abs <= '0;
        else if (start)                     peak_abs <= '0;
        else if (wr_ok && in_abs > peak_abs) peak_abs <= in_abs;
    end
`else
    assign peak_abs = '0;
`endif

endmodule

// File: tb/tb_opti_result_capture.sv
// tb/tb_opti_result_capture.sv - table-driven self-checking bench for opti_result_capture
module tb_opti_result_capture;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    logic              clk, rst_n, arm, in_valid, in_stable, in_done, rd_ready;
    logic [DATA_W-1:0] in_data, rd_data, peak_abs;
    logic              rd_valid, rd_last, busy, overflow, cap_done;
    logic [ADDR_W:0]   cap_count;

    opti_result_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .in_data(in_data), .in_valid(in_valid),
        .in_stable(in_stable), .in_done(in_done), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_last(rd_last), .cap_count(cap_count), .busy(busy),
        .overflow(overflow), .cap_done(cap_done), .peak_abs(peak_abs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n_unst;
        int          n_st;
        logic [15:0] base;
        logic [15:0] step;
        bit          done_wl;
        int          mode;
        int          exp_cnt;
        bit          exp_ovf;
        logic [15:0] exp_peak;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] samp [0:2099];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [15:0] pk(input logic [15:0] v);
`ifdef OPTI_CAPTURE_PEAK_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic capture(input int n_unst, input int n_st, input bit done_wl);
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_cap_count", cap_count, 0);
        chk("arm_overflow", overflow, 0);
        chk("arm_cap_done", cap_done, 0);
        chk("arm_peak_clear", peak_abs, 0);
        for (int i = 0; i < n_unst + n_st; i++) begin
            in_valid  = 1'b1;
            in_stable = (i >= n_unst);
            in_data   = (i >= n_unst) ? samp[i-n_unst] : (16'h5A00 + 16'(i));
            in_done   = done_wl && (i == n_unst + n_st - 1);
            @(negedge clk);
        end
        if (!done_wl) begin
            in_valid  = 1'b0;
            in_stable = 1'b0;
            in_done   = 1'b1;
            @(negedge clk);
        end
        in_done   = 1'b0;
        in_valid  = 1'b0;
        in_stable = 1'b0;
    endtask

    task automatic drain(input int n, input int mode);
        int          idx = 0, cyc = 0, first = -1, lastc = 0;
        bit          held = 0;
        logic [15:0] hd = '0;
        logic        hl = 0;
        chk("drain_first_cycle_idle", rd_valid, 0);
        while (idx < n && cyc < 4*n + 20) begin
            @(negedge clk);
            rd_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (held) begin
                checks++;
                if (!rd_valid || rd_data !== hd || rd_last !== hl) begin
                    errors++;
                    $display("FAIL hold word %0d: got v=%0b d=0x%0h l=%0b expected v=1 d=0x%0h l=%0b",
                             idx, rd_valid, rd_data, rd_last, hd, hl);
                end
            end
            if (rd_valid && first < 0) begin
                first = cyc;
                chk("first_valid_latency", cyc, 0);
            end
            if (rd_valid && rd_ready) begin
                chk($sformatf("rd_data[%0d]", idx), rd_data, samp[idx]);
                chk($sformatf("rd_last[%0d]", idx), rd_last, (idx == n - 1));
                idx++;
                lastc = cyc;
                held  = 0;
            end else if (rd_valid) begin
                held = 1;
                hd   = rd_data;
                hl   = rd_last;
            end else begin
                held = 0;
            end
            cyc++;
        end
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words expected %0d", idx, n);
        end
        if (mode == 0) chk("no_bubbles", lastc - first + 1, n);
        @(negedge clk);
        rd_ready = 1'b0;
        chk("end_rd_valid", rd_valid, 0);
        chk("end_cap_done", cap_done, 1);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        int got;
        bit seen;
        rst_n = 1'b0; arm = 1'b0; in_data = '0; in_valid = 1'b0;
        in_stable = 1'b0; in_done = 1'b0; rd_ready = 1'b0;

        vecs[0] = '{5, 3,    16'h0010, 16'h0010, 1'b0, 0, 3,    1'b0, 16'h0030};
        vecs[1] = '{2, 6,    16'h1234, 16'h0111, 1'b1, 1, 6,    1'b0, 16'h1789};
        vecs[2] = '{0, 1,    16'h8001, 16'h0000, 1'b0, 1, 1,    1'b0, 16'h7FFF};
        vecs[3] = '{0, 2050, 16'h0000, 16'h0001, 1'b0, 0, 2048, 1'b1, 16'h07FF};

        repeat (3) @(negedge clk);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cap_count", cap_count, 0);
        chk("rst_cap_done", cap_done, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vecs[v].n_st; i++) samp[i] = vecs[v].base + 16'(i) * vecs[v].step;
            capture(vecs[v].n_unst, vecs[v].n_st, vecs[v].done_wl);
            chk($sformatf("v%0d_cap_count", v), cap_count, vecs[v].exp_cnt);
            chk($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_ovf);
            chk($sformatf("v%0d_peak", v), peak_abs, pk(vecs[v].exp_peak));
            drain(vecs[v].exp_cnt, vecs[v].mode);
            chk($sformatf("v%0d_overflow_sticky", v), overflow, vecs[v].exp_ovf);
        end

        // Done with an empty buffer goes straight to DONE with no read traffic
        capture(3, 0, 1'b0);
        chk("empty_cap_done", cap_done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_cap_count", cap_count, 0);
        rd_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_valid) seen = 1;
        end
        chk("empty_no_rd_valid", seen, 0);
        rd_ready = 1'b0;

        // Reset in the middle of a drain
        for (int i = 0; i < 20; i++) samp[i] = 16'h0100 + 16'(3 * i);
        capture(0, 20, 1'b0);
        rd_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 10; k++) begin
            @(negedge clk);
            if (rd_valid) got++;
        end
        chk("mid_drain_words", got, 10);
        @(posedge clk);
        #2;
        chk("pre_reset_rd_valid", rd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_rd_data", rd_data, 0);
        chk("async_rst_rd_last", rd_last, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cap_count", cap_count, 0);
        chk("async_rst_peak", peak_abs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_ready = 1'b0;
        @(negedge clk);
        samp[0] = 16'h7FFF;
        capture(0, 1, 1'b0);
        chk("rearm_cap_count", cap_count, 1);
        drain(1, 0);

        // Peak with the most negative value saturating
        samp[0] = 16'h0100; samp[1] = 16'h8000; samp[2] = 16'hFF00;
        capture(0, 3, 1'b0);
        chk("peak_saturate", peak_abs, pk(16'h7FFF));
        drain(3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
